mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl_if.sv | 28 ++
 rtl/mac_ctrl.sv | 131 +++++++++++++
 tb/tb_mac_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mac_ctrl_if.sv
// Control/status bundle between a MAC job requester and the mac_ctrl sequencer.
// The master side drives the job request; the slave side is the sequencer itself.
interface mac_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic              abort_i;
  logic [ADDR_W-1:0] len_i;
  logic [5:0]        frac_i;
  logic [ADDR_W-1:0] addr_o;
  logic              clr_o;
  logic              en_o;
  logic [5:0]        s_o;
  logic              load_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, abort_i, len_i, frac_i,
    input  addr_o, clr_o, en_o, s_o, load_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, abort_i, len_i, frac_i,
    output addr_o, clr_o, en_o, s_o, load_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/mac_ctrl.sv
// Sequencer for one multiply-accumulate job: clears the accumulator, walks the
// operand addresses, lines the accumulate enable up with the product pipeline.
//
//   state | meaning
//   IDLE  | waiting for start_i; rejects frac_i > 42 with an err_o pulse
//   CLEAR | one cycle, clr_o=1
//   RUN   | len_q cycles, addr_o = 0 .. len_q-1
//   DRAIN | PIPE cycles while the last products reach the accumulator
//   LOAD  | one cycle, load_o=1
//   DONE  | one cycle, done_o=1
module mac_ctrl #(
  parameter int ADDR_W = 8,
  parameter int PIPE   = 2
) (
  input logic       clk_i,
  input logic       rst_i,
  mac_ctrl_if.slave bus
);

  localparam int CNT_W = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic [PIPE-1:0]   vld;
  logic [5:0]        s_q;
  logic              clr_q;
  logic              load_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  assign bus.addr_o = addr_q;
  assign bus.clr_o  = clr_q;
  assign bus.en_o   = vld[PIPE-1];
  assign bus.s_o    = s_q;
  assign bus.load_o = load_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
      vld       <= '0;
      s_q       <= '0;
      clr_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // Valid tracker: one bit per address issued, PIPE cycles ahead of en_o.
      vld[0] <= (state == RUN);
      for (int i = 1; i < PIPE; i++) vld[i] <= vld[i-1];

      if (state != IDLE && bus.abort_i) begin
        state  <= IDLE;
        vld    <= '0;
        addr_q <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i) begin
              if (bus.frac_i <= 6'd42) begin
                len_q  <= bus.len_i;
                s_q    <= bus.frac_i;
                clr_q  <= 1'b1;
                busy_q <= 1'b1;
                state  <= CLEAR;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          CLEAR: begin
            addr_q <= '0;
            if (len_q == '0) begin
              load_q <= 1'b1;
              state  <= LOAD;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            if (addr_q == len_q - ADDR_W'(1)) begin
              addr_q    <= '0;
              drain_cnt <= CNT_W'(PIPE - 1);
              state     <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
          DRAIN: begin
            if (drain_cnt == '0) begin
              load_q <= 1'b1;
              state  <= LOAD;
            end else begin
              drain_cnt <= drain_cnt - CNT_W'(1);
            end
          end
          LOAD: begin
            done_q <= 1'b1;
            state  <= DONE;
          end
          DONE: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// Bench for mac_ctrl: directed job scenarios followed by randomized jobs, each
// cycle compared against a timeline derived from the job length and PIPE.
module tb_mac_ctrl;

  localparam int AW   = 8;
  localparam int PIPE = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;
  int job_no = 0;
  int s_exp  = 0;

  mac_ctrl_if #(.ADDR_W(AW)) bus ();

  mac_ctrl #(.ADDR_W(AW), .PIPE(PIPE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s job=%0d t=%0t got=%0h exp=%0h", tag, job_no, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outs(input int a, input bit c, input bit e, input int s,
                            input bit l, input bit b, input bit d, input bit er,
                            input bit chk_en);
    chk("addr", 32'(bus.addr_o), 32'(a));
    chk("clr", 32'(bus.clr_o), 32'(c));
    if (chk_en) chk("en", 32'(bus.en_o), 32'(e));
    chk("s", 32'(bus.s_o), 32'(s));
    chk("load", 32'(bus.load_o), 32'(l));
    chk("busy", 32'(bus.busy_o), 32'(b));
    chk("done", 32'(bus.done_o), 32'(d));
    chk("err", 32'(bus.err_o), 32'(er));
  endtask

  // Cycle k=1 is the first cycle after start_i is sampled (CLEAR).
  // noise: 0 quiet, 1 random start/len/frac while busy, 2 one start pulse with len=3 at k=3
  task automatic run_job(input int len, input int frac, input int abort_k,
                         input int rst_k, input int noise);
    int last;
    int en_cnt;
    int e_addr;
    bit e_en;
    job_no++;
    bus.start_i = 1'b1;
    bus.len_i   = len[AW-1:0];
    bus.frac_i  = frac[5:0];
    bus.abort_i = (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    if (frac > 42) begin
      check_outs(0, 0, 0, s_exp, 0, 0, 0, 1, 1);
      step();
      check_outs(0, 0, 0, s_exp, 0, 0, 0, 0, 1);
      return;
    end
    s_exp  = frac;
    last   = (len == 0) ? 3 : len + PIPE + 3;
    en_cnt = 0;
    for (int k = 1; k <= last + 1; k++) begin
      if (k > 1) step();
      e_addr = (k >= 2 && k <= len + 1) ? k - 2 : 0;
      e_en   = (len > 0) && (k >= PIPE + 2) && (k <= len + PIPE + 1);
      check_outs(e_addr, k == 1, e_en, s_exp, k == last - 1, k <= last, k == last, 0, 1);
      if (bus.en_o) en_cnt++;
      if (k == abort_k) begin
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        check_outs(0, 0, 0, s_exp, 0, 0, 0, 0, 0);
        return;
      end
      if (k == rst_k) begin
        #2 rst_i = 1'b0;
        #1;
        s_exp = 0;
        check_outs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        rst_i = 1'b1;
        return;
      end
      if (noise == 1 && k <= last) begin
        bus.start_i = 1'($urandom_range(0, 1));
        bus.len_i   = AW'($urandom_range(0, 255));
        bus.frac_i  = 6'($urandom_range(0, 63));
      end else if (noise == 2) begin
        bus.start_i = (k == 3);
        bus.len_i   = (k == 3) ? AW'(3) : len[AW-1:0];
      end
    end
    bus.start_i = 1'b0;
    chk("en_count", 32'(en_cnt), 32'(len));
  endtask

  initial begin
    int len, frac, last, ak;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.len_i   = '0;
    bus.frac_i  = '0;
    #2 rst_i = 1'b0;
    #1;
    check_outs(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();
    rst_i = 1'b1;

    run_job(4, 16, 0, 0, 0);
    run_job(0, 0, 0, 0, 0);
    run_job(6, 43, 0, 0, 0);
    run_job(8, 10, 3, 0, 0);
    run_job(2, 5, 0, 0, 0);
    run_job(5, 20, 0, 0, 2);
    run_job(3, 7, 0, 5, 0);
    run_job(1, 9, 0, 0, 0);
    run_job(7, 63, 0, 0, 0);
    run_job(255, 42, 0, 0, 0);

    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check_outs(0, 0, 0, s_exp, 0, 0, 0, 0, 1);

    for (int j = 0; j < 40; j++) begin
      len  = $urandom_range(0, 12);
      frac = ($urandom_range(0, 7) == 0) ? $urandom_range(43, 63) : $urandom_range(0, 42);
      last = (len == 0) ? 3 : len + PIPE + 3;
      ak   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, last - 1) : 0;
      run_job(len, frac, ak, 0, 1);
    end

    step();
    check_outs(0, 0, 0, s_exp, 0, 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
